lsu: RTL and testbench
======================

# lsu

Load/store unit forming the CPU's data memory stage. Sits directly downstream of the ALU stage: it takes the ALU result (effective address or arithmetic result) plus the decoded memory and writeback controls. It runs a single-outstanding request/ready transaction on the data memory port, aligns and sign-extends load data, and presents a registered writeback bundle. While an access is in flight it stalls the pipeline.

## Interface
- ADDR_W, 11, word-address width of the data memory port.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  ALU-stage bundle valid.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_reg_write  in  1  instruction writes rd.
- i_rd  in  5  destination register.
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_alu_result  in  32  byte address for memory ops, result otherwise.
- i_store_data  in  32  rs2 value for stores.
- o_stall  out  1  inputs not consumed this cycle; upstream must hold them.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  request is a write.
- o_mem_addr  out  ADDR_W  word address.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ready  in  1  request completes this cycle; rdata valid.
- i_mem_rdata  in  32  read word.
- o_wb_valid  out  1  writeback bundle valid (one cycle).
- o_wb_reg_write  out  1  write o_wb_data to o_wb_rd.
- o_wb_rd  out  5  destination register.
- o_wb_data  out  32  writeback value.
- o_misaligned  out  1  one-cycle exception pulse.

## Operation
- Memory op: i_mem_read or i_mem_write is set. i_mem_read and i_mem_write never both set.
- States: IDLE, ACCESS.
- IDLE, !i_valid: nothing happens. Next cycle o_wb_valid=0.
- IDLE, valid non-memory op: consumed, o_stall=0. Next cycle o_wb_valid=1, o_wb_data=i_alu_result, o_wb_rd=i_rd, o_wb_reg_write=i_reg_write.
- IDLE, valid aligned memory op: o_stall=1. At the edge, register the request fields and go to ACCESS:
  - o_mem_req=1.
  - o_mem_we=i_mem_write.
  - o_mem_addr=i_alu_result[ADDR_W+1:2].
  - o_mem_be, o_mem_wdata, plus internally addr[1:0], funct3, rd.
- IDLE, valid misaligned memory op: no request is made and the op is consumed (o_stall=0).
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Next cycle o_misaligned=1, o_wb_valid=0.
- ACCESS: request fields are held constant. o_stall=!i_mem_ready.
- ACCESS with i_mem_ready=1: the op is consumed, state returns to IDLE and o_mem_req drops. Next cycle o_wb_valid=1, and:
  - load: o_wb_reg_write=1 and o_wb_data holds the extracted data.
  - store: o_wb_reg_write=0.
- Byte enables and store data:
  - B: be=1<<addr[1:0], wdata={4{d[7:0]}}.
  - H: be = addr[1] ? 1100 : 0011, wdata={2{d[15:0]}}.
  - W: be=1111, wdata=d.
  - Loads drive the same be pattern with we=0.
- Load extraction: select the byte or halfword lane by the registered addr[1:0].
  - B and H sign-extend to 32 bits.
  - BU and HU zero-extend.
  - W passes through.
- Funct3 values not listed (011, 110, 111) on memory ops are treated as W.
- i_mem_ready outside ACCESS is ignored.

## Timing
- Reset: state IDLE. Every output is 0, including o_mem_addr, o_mem_be, o_mem_wdata and o_wb_data.
- Reset mid-ACCESS aborts the transaction immediately. No writeback is produced and o_mem_req is 0 while reset is asserted.
- o_stall is combinational from inputs and state. All other outputs are registered.
- Non-memory op: 1-cycle latency, no stall.
- Memory op with zero-wait memory (i_mem_ready high in the first ACCESS cycle):
  - cycle 0: presented, stalled.
  - cycle 1: o_mem_req=1, ready=1, consumed.
  - cycle 2: o_wb_valid=1.
- Each wait cycle adds exactly one stall cycle.
- A new op may be presented in the cycle immediately after consumption. Back-to-back loads therefore issue one request every 2 cycles.
- o_wb_valid and o_misaligned are single-cycle pulses and are never both high.

## Test plan
- Non-memory pass-through: i_alu_result=0x1234_5678, rd=7, reg_write=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=7, stall never high.
- LB at 0x0000_0403, rdata=0x80FF_0000, ready in the first ACCESS cycle:
  - o_mem_addr=0x100, be=1000, we=0.
  - wb_data=0xFFFF_FF80 two cycles after presentation.
  - LBU same stimulus -> wb_data=0x0000_0080.
- SH at 0x0000_0012, store_data=0xAAAA_BEEF, ready delayed 3 cycles:
  - be=1100, wdata=0xBEEF_BEEF; request fields stable.
  - o_stall high for 4 cycles, then wb_valid=1 with wb_reg_write=0.
- LW at 0x0000_0006 -> no o_mem_req, stall=0, next cycle o_misaligned=1, wb_valid=0.
- Back-to-back LW 0x0, LW 0x4 with ready tied high -> requests in cycles 1 and 3, writebacks in cycles 2 and 4 with the correct data.
- Assert i_rst during ACCESS with ready low -> o_mem_req and all outputs 0 immediately. After release the unit is in IDLE and the aborted load never writes back.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: single-outstanding data memory access with load alignment/extension.
// Latency 1 cycle for ALU pass-through, 2+wait cycles for memory ops; o_stall holds upstream while busy.
module lsu #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_reg_write,
  input  logic [4:0]        i_rd,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_store_data,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_reg_write,
  output logic [4:0]        o_wb_rd,
  output logic [31:0]       o_wb_data,
  output logic              o_misaligned
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state;
  logic [2:0] f3_q;
  logic [1:0] alo_q;
  logic [4:0] rd_q;

  logic        is_mem, is_b, is_h, misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, rsh, ld_data;
  logic [15:0] half;

  // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word access
  always_comb begin
    is_mem     = i_mem_read | i_mem_write;
    is_b       = (i_funct3[1:0] == 2'b00);
    is_h       = (i_funct3[1:0] == 2'b01);
    misaligned = is_h ? i_alu_result[0] : (!is_b && (i_alu_result[1:0] != 2'b00));
    be_n       = 4'b1111;
    wdata_n    = i_store_data;
    if (is_b) begin
      be_n    = 4'b0001 << i_alu_result[1:0];
      wdata_n = {4{i_store_data[7:0]}};
    end else if (is_h) begin
      be_n    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      wdata_n = {2{i_store_data[15:0]}};
    end
  end

  always_comb begin
    rsh     = i_mem_rdata >> {alo_q, 3'b000};
    half    = alo_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    ld_data = i_mem_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b100:  ld_data = {24'h0, rsh[7:0]};
      3'b001:  ld_data = {{16{half[15]}}, half};
      3'b101:  ld_data = {16'h0, half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  assign o_stall = (state == IDLE)   ? (i_valid && is_mem && !misaligned)
                                     : !i_mem_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      f3_q           <= '0;
      alo_q          <= '0;
      rd_q           <= '0;
      o_mem_req      <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_be       <= '0;
      o_mem_wdata    <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_reg_write <= 1'b0;
      o_wb_rd        <= '0;
      o_wb_data      <= '0;
      o_misaligned   <= 1'b0;
    end else begin
      o_wb_valid     <= 1'b0;
      o_wb_reg_write <= 1'b0;
      o_misaligned   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (!is_mem) begin
              o_wb_valid     <= 1'b1;
              o_wb_reg_write <= i_reg_write;
              o_wb_rd        <= i_rd;
              o_wb_data      <= i_alu_result;
            end else if (misaligned) begin
              o_misaligned <= 1'b1;
            end else begin
              state       <= ACCESS;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_mem_write;
              o_mem_addr  <= i_alu_result[ADDR_W+1:2];
              o_mem_be    <= be_n;
              o_mem_wdata <= wdata_n;
              alo_q       <= i_alu_result[1:0];
              f3_q        <= i_funct3;
              rd_q        <= i_rd;
            end
          end
        end
        ACCESS: begin
          if (i_mem_ready) begin
            state          <= IDLE;
            o_mem_req      <= 1'b0;
            o_wb_valid     <= 1'b1;
            o_wb_reg_write <= !o_mem_we;
            o_wb_rd        <= rd_q;
            if (!o_mem_we) o_wb_data <= ld_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads of every size, waited store, misalignment, back-to-back, reset abort.
module tb_lsu;
  localparam int ADDR_W = 11;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid, i_mem_read, i_mem_write, i_reg_write;
  logic [4:0]        i_rd;
  logic [2:0]        i_funct3;
  logic [31:0]       i_alu_result, i_store_data;
  logic              o_stall, o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [3:0]        o_mem_be;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_ready;
  logic [31:0]       i_mem_rdata;
  logic              o_wb_valid, o_wb_reg_write;
  logic [4:0]        o_wb_rd;
  logic [31:0]       o_wb_data;
  logic              o_misaligned;

  int errors = 0;
  int checks = 0;

  lsu #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_reg_write(i_reg_write), .i_rd(i_rd), .i_funct3(i_funct3),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .o_stall(o_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_reg_write(o_wb_reg_write), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic clr_in();
    i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_reg_write = 0; i_rd = 0;
    i_funct3 = 0; i_alu_result = 0; i_store_data = 0; i_mem_ready = 0; i_mem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    logic [88:0] regs;
    i_rst = 1; clr_in();
    tick(); tick();
    regs = {o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_wb_valid,
            o_wb_reg_write, o_wb_rd, o_wb_data, o_misaligned};
    checks++; if (regs !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", regs); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", o_stall); end
    i_rst = 0;
    tick();
  endtask

  task automatic test_passthrough();
    i_valid = 1; i_reg_write = 1; i_rd = 7; i_alu_result = 32'h1234_5678;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL pass_stall got=%b want=0", o_stall); end
    tick(); clr_in();
    checks++; if ({o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_mem_req} !== {1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b0}) begin
      errors++; $display("FAIL pass_wb got valid=%b rw=%b rd=%0d data=%h req=%b want 1 1 7 12345678 0",
                         o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_mem_req);
    end
    tick();
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL pass_wb_pulse got=%b want=0", o_wb_valid); end
  endtask

  task automatic run_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdat, input logic [3:0] exp_be, input logic [31:0] exp_data);
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = addr[ADDR_W+1:2];
    i_valid = 1; i_mem_read = 1; i_rd = 5'd3; i_funct3 = f3; i_alu_result = addr;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL %s_stall0 got=%b want=1", name, o_stall); end
    tick();
    checks++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be} !== {1'b1, 1'b0, exp_addr, exp_be}) begin
      errors++; $display("FAIL %s_req got req=%b we=%b addr=%h be=%b want 1 0 %h %b",
                         name, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, exp_addr, exp_be);
    end
    i_mem_ready = 1; i_mem_rdata = rdat;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL %s_stall1 got=%b want=0", name, o_stall); end
    tick(); clr_in();
    checks++; if ({o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_mem_req} !== {1'b1, 1'b1, 5'd3, exp_data, 1'b0}) begin
      errors++; $display("FAIL %s_wb got valid=%b rw=%b rd=%0d data=%h req=%b want 1 1 3 %h 0",
                         name, o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_mem_req, exp_data);
    end
  endtask

  task automatic test_loads();
    run_load("lb",   32'h0000_0403, 3'b000, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    run_load("lbu",  32'h0000_0403, 3'b100, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    run_load("lb1",  32'h0000_0001, 3'b000, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
    run_load("lh",   32'h0000_0402, 3'b001, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    run_load("lhu",  32'h0000_0000, 3'b101, 32'h8001_9234, 4'b0011, 32'h0000_9234);
    run_load("lw",   32'h0000_0010, 3'b010, 32'h8765_4321, 4'b1111, 32'h8765_4321);
    run_load("f011", 32'h0000_0008, 3'b011, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    i_valid = 1; i_mem_write = 1; i_funct3 = 3'b001; i_alu_result = 32'h0000_0012;
    i_store_data = 32'hAAAA_BEEF;
    #1; if (o_stall) stalls++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) i_mem_ready = 1;
      #1; if (o_stall) stalls++;
      checks++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !==
                    {1'b1, 1'b1, 11'h004, 4'b1100, 32'hBEEF_BEEF}) begin
        errors++; $display("FAIL sh_fields%0d got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 004 1100 beefbeef",
                           i, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata);
      end
    end
    checks++; if (stalls != 4) begin errors++; $display("FAIL sh_stall_cycles got=%0d want=4", stalls); end
    tick(); clr_in();
    checks++; if ({o_wb_valid, o_wb_reg_write, o_mem_req} !== 3'b100) begin
      errors++; $display("FAIL sh_wb got valid=%b rw=%b req=%b want 1 0 0", o_wb_valid, o_wb_reg_write, o_mem_req);
    end
  endtask

  task automatic test_misaligned();
    i_valid = 1; i_mem_read = 1; i_funct3 = 3'b010; i_alu_result = 32'h0000_0006; i_rd = 4;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got=%b want=0", o_stall); end
    tick(); clr_in();
    checks++; if ({o_misaligned, o_wb_valid, o_mem_req} !== 3'b100) begin
      errors++; $display("FAIL mis_pulse got mis=%b wbv=%b req=%b want 1 0 0", o_misaligned, o_wb_valid, o_mem_req);
    end
    tick();
    checks++; if (o_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b want=0", o_misaligned); end
  endtask

  task automatic test_back_to_back();
    i_mem_ready = 1;
    i_valid = 1; i_mem_read = 1; i_funct3 = 3'b010; i_alu_result = 32'h0; i_rd = 1;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall0 got=%b want=1", o_stall); end
    tick();
    checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 11'h000}) begin
      errors++; $display("FAIL b2b_req1 got req=%b addr=%h want 1 000", o_mem_req, o_mem_addr);
    end
    i_mem_rdata = 32'hC0DE_0000;
    tick();
    checks++; if ({o_wb_valid, o_wb_rd, o_wb_data, o_mem_req} !== {1'b1, 5'd1, 32'hC0DE_0000, 1'b0}) begin
      errors++; $display("FAIL b2b_wb1 got valid=%b rd=%0d data=%h req=%b want 1 1 c0de0000 0",
                         o_wb_valid, o_wb_rd, o_wb_data, o_mem_req);
    end
    i_alu_result = 32'h4; i_rd = 2;
    tick();
    checks++; if ({o_mem_req, o_mem_addr, o_wb_valid} !== {1'b1, 11'h001, 1'b0}) begin
      errors++; $display("FAIL b2b_req2 got req=%b addr=%h wbv=%b want 1 001 0", o_mem_req, o_mem_addr, o_wb_valid);
    end
    i_mem_rdata = 32'hC0DE_0001;
    tick(); clr_in();
    checks++; if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd2, 32'hC0DE_0001}) begin
      errors++; $display("FAIL b2b_wb2 got valid=%b rd=%0d data=%h want 1 2 c0de0001", o_wb_valid, o_wb_rd, o_wb_data);
    end
  endtask

  task automatic test_reset_abort();
    logic [88:0] regs;
    i_valid = 1; i_mem_read = 1; i_funct3 = 3'b010; i_alu_result = 32'h8; i_rd = 9;
    tick();
    checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL abort_req got=%b want=1", o_mem_req); end
    i_rst = 1;
    #1;
    regs = {o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_wb_valid,
            o_wb_reg_write, o_wb_rd, o_wb_data, o_misaligned};
    checks++; if (regs !== '0) begin errors++; $display("FAIL abort_outputs got=%h want=0", regs); end
    clr_in();
    tick();
    i_rst = 0;
    i_mem_ready = 1; i_mem_rdata = 32'h1111_2222;
    tick();
    checks++; if ({o_wb_valid, o_mem_req} !== 2'b00) begin
      errors++; $display("FAIL abort_no_wb got wbv=%b req=%b want 0 0", o_wb_valid, o_mem_req);
    end
    i_mem_ready = 0;
    i_valid = 1; i_reg_write = 1; i_rd = 5; i_alu_result = 32'h55;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL abort_idle_stall got=%b want=0", o_stall); end
    tick(); clr_in();
    checks++; if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd5, 32'h55}) begin
      errors++; $display("FAIL abort_idle_wb got valid=%b rd=%0d data=%h want 1 5 00000055", o_wb_valid, o_wb_rd, o_wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_store_wait();
    test_misaligned();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
